// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: drives a 3-input gate through all eight input vectors and
// samples its output after SETTLE extra hold cycles per vector. The measured
// truth table is assembled MSB-first (vector 000 -> bit 7) and compared
// against EXPECTED.
// Optional feature: define TT_SWEEP_ERRCNT_EN to count mismatching table bits
// on err_cnt; otherwise err_cnt is tied to zero.
module tt_sweep_capture #(
  parameter int unsigned SETTLE   = 3,
  parameter logic [7:0]  EXPECTED = 8'hB2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       drv_in1,
  output logic       drv_in2,
  output logic       drv_in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt_q,
  output logic       match,
  output logic [3:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  state_t     state_q;
  logic [2:0] v_q;
  logic [7:0] hold_q;
  logic [7:0] shadow_q;
  logic [7:0] shadow_d;
  logic       busy_q;
  logic       done_q;
  logic       match_q;
  logic       start_acc;
  logic       sample;
  logic       last_sample;

  // Sweep control strobes and the shadow table with the current sample merged in
  always_comb begin
    start_acc   = (state_q == IDLE) && start && !abort;
    sample      = (state_q == SWEEP) && !abort && (hold_q == SETTLE_C);
    last_sample = sample && (v_q == 3'd7);
    shadow_d    = shadow_q;
    shadow_d[~v_q] = dut_out;
  end

  // Sweep FSM: vector index, hold counter, shadow capture and result publication
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      v_q      <= '0;
      hold_q   <= '0;
      shadow_q <= '0;
      tt_q     <= '0;
      match_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_acc) begin
            state_q  <= SWEEP;
            v_q      <= '0;
            hold_q   <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        SWEEP: begin
          if (abort) begin
            state_q <= IDLE;
            v_q     <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
          end else if (sample) begin
            shadow_q <= shadow_d;
            hold_q   <= '0;
            // v wraps 7 -> 0 here, so the gate inputs return to 000 in DONE
            v_q      <= v_q + 3'd1;
            if (last_sample) begin
              state_q <= DONE;
              tt_q    <= shadow_d;
              match_q <= (shadow_d == EXPECTED);
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          v_q     <= '0;
          hold_q  <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign drv_in1 = v_q[2];
  assign drv_in2 = v_q[1];
  assign drv_in3 = v_q[0];
  assign busy    = busy_q;
  assign done    = done_q;
  assign match   = match_q;

`ifdef TT_SWEEP_ERRCNT_EN
  logic [3:0] err_acc_q;
  logic [3:0] err_acc_d;

  // Running mismatch count for the current sweep including this sample
  always_comb begin
    err_acc_d = err_acc_q + {3'b000, (dut_out != EXPECTED[~v_q])};
  end

  // Accumulate per sample; clear on sweep start, publish only on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      err_acc_q <= '0;
      err_cnt   <= '0;
    end else if (start_acc) begin
      err_acc_q <= '0;
    end else if (sample) begin
      err_acc_q <= err_acc_d;
      if (last_sample) begin
        err_cnt <= err_acc_d;
      end
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture: SETTLE=3 instance against a behavioural
// 0xB2 gate (optionally inverted) and a SETTLE=0 instance with a stuck-1 gate.
module tb_tt_sweep_capture;

`ifdef TT_SWEEP_ERRCNT_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  // Instance A: SETTLE=3
  logic       start_a, abort_a, inv_a, dout_a;
  logic       drv1_a, drv2_a, drv3_a, busy_a, done_a, match_a;
  logic [7:0] tt_a;
  logic [3:0] err_a;
  logic [2:0] drv_a;
  // Instance B: SETTLE=0, gate output stuck at 1
  logic       start_b, abort_b, dout_b;
  logic       drv1_b, drv2_b, drv3_b, busy_b, done_b, match_b;
  logic [7:0] tt_b;
  logic [3:0] err_b;
  logic [2:0] drv_b;

  logic [7:0] gate_tt = 8'hB2;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign drv_a  = {drv1_a, drv2_a, drv3_a};
  assign drv_b  = {drv1_b, drv2_b, drv3_b};
  assign dout_a = gate_tt[3'd7 - drv_a] ^ inv_a;
  assign dout_b = 1'b1;

  tt_sweep_capture #(.SETTLE(3), .EXPECTED(8'hB2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .dut_out(dout_a),
    .drv_in1(drv1_a), .drv_in2(drv2_a), .drv_in3(drv3_a),
    .busy(busy_a), .done(done_a), .tt_q(tt_a), .match(match_a), .err_cnt(err_a)
  );

  tt_sweep_capture #(.SETTLE(0), .EXPECTED(8'hB2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .dut_out(dout_b),
    .drv_in1(drv1_b), .drv_in2(drv2_b), .drv_in3(drv3_b),
    .busy(busy_b), .done(done_b), .tt_q(tt_b), .match(match_b), .err_cnt(err_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if ({busy_a, done_a, drv_a, tt_a, match_a, err_a} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_a: got busy=%b done=%b drv=%b tt=%h match=%b err=%0d, want all zero",
               busy_a, done_a, drv_a, tt_a, match_a, err_a);
    end
    n_checks++;
    if ({busy_b, done_b, drv_b, tt_b, match_b, err_b} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_b: got busy=%b done=%b drv=%b tt=%h match=%b err=%0d, want all zero",
               busy_b, done_b, drv_b, tt_b, match_b, err_b);
    end
  endtask

  // Full sweep on instance A: vector sequence, done timing and published result
  task automatic test_sweep(input logic inv, input logic [7:0] exp_tt,
                            input logic exp_match, input logic [3:0] exp_err);
    inv_a   = inv;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if ({busy_a, done_a, drv_a} !== {1'b1, 1'b0, 3'(k / 4)}) begin
        n_fail++;
        $display("FAIL sweep_seq k=%0d: got busy=%b done=%b drv=%b, want busy=1 done=0 drv=%b",
                 k, busy_a, done_a, drv_a, 3'(k / 4));
      end
      tick();
    end
    n_checks++;
    if ({busy_a, done_a, drv_a} !== 5'b01000) begin
      n_fail++;
      $display("FAIL sweep_done: got busy=%b done=%b drv=%b, want busy=0 done=1 drv=000",
               busy_a, done_a, drv_a);
    end
    n_checks++;
    if ({tt_a, match_a, err_a} !== {exp_tt, exp_match, exp_err}) begin
      n_fail++;
      $display("FAIL sweep_result: got tt=%h match=%b err=%0d, want tt=%h match=%b err=%0d",
               tt_a, match_a, err_a, exp_tt, exp_match, exp_err);
    end
    tick();
    n_checks++;
    if ({busy_a, done_a} !== 2'b00) begin
      n_fail++;
      $display("FAIL done_pulse: got busy=%b done=%b one cycle later, want 0 0", busy_a, done_a);
    end
    inv_a = 1'b0;
  endtask

  task automatic test_settle0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({busy_b, done_b, drv_b} !== {1'b1, 1'b0, 3'(k)}) begin
        n_fail++;
        $display("FAIL settle0_seq k=%0d: got busy=%b done=%b drv=%b, want 1 0 %b",
                 k, busy_b, done_b, drv_b, 3'(k));
      end
      tick();
    end
    n_checks++;
    if ({busy_b, done_b, drv_b, tt_b, match_b, err_b} !==
        {1'b0, 1'b1, 3'b000, 8'hFF, 1'b0, (ERR_ON ? 4'd4 : 4'd0)}) begin
      n_fail++;
      $display("FAIL settle0_done: got busy=%b done=%b drv=%b tt=%h match=%b err=%0d, want 0 1 000 ff 0 %0d",
               busy_b, done_b, drv_b, tt_b, match_b, err_b, (ERR_ON ? 4 : 0));
    end
    tick();
  endtask

  // Abort at vector 5 with an inverted gate: prior good result must survive
  task automatic test_abort;
    inv_a   = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (drv_a !== 3'd5) begin
      n_fail++;
      $display("FAIL abort_setup: got drv=%b, want 101", drv_a);
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({busy_a, done_a, drv_a, tt_a, match_a, err_a} !==
          {1'b0, 1'b0, 3'b000, 8'hB2, 1'b1, 4'd0}) begin
        n_fail++;
        $display("FAIL abort k=%0d: got busy=%b done=%b drv=%b tt=%h match=%b err=%0d, want 0 0 000 b2 1 0",
                 k, busy_a, done_a, drv_a, tt_a, match_a, err_a);
      end
      tick();
    end
    inv_a = 1'b0;
    // start together with abort in IDLE stays idle
    start_a = 1'b1;
    abort_a = 1'b1;
    tick();
    start_a = 1'b0;
    abort_a = 1'b0;
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL start_abort_idle: got busy=%b, want 0", busy_a);
    end
  endtask

  // start held high: one DONE and one IDLE cycle between sweeps, no restart mid-sweep
  task automatic test_back_to_back;
    start_a = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if ({busy_a, drv_a} !== {1'b1, 3'(k / 4)}) begin
        n_fail++;
        $display("FAIL b2b_seq1 k=%0d: got busy=%b drv=%b, want 1 %b", k, busy_a, drv_a, 3'(k / 4));
      end
      tick();
    end
    n_checks++;
    if ({busy_a, done_a} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_done: got busy=%b done=%b, want 0 1", busy_a, done_a);
    end
    tick();
    n_checks++;
    if ({busy_a, done_a} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", busy_a, done_a);
    end
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k == 9) start_a = 1'b1;
      if (k == 10) start_a = 1'b0;
      n_checks++;
      if ({busy_a, drv_a} !== {1'b1, 3'(k / 4)}) begin
        n_fail++;
        $display("FAIL b2b_seq2 k=%0d: got busy=%b drv=%b, want 1 %b", k, busy_a, drv_a, 3'(k / 4));
      end
      tick();
    end
    n_checks++;
    if ({done_a, tt_a, match_a} !== {1'b1, 8'hB2, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_result: got done=%b tt=%h match=%b, want 1 b2 1", done_a, tt_a, match_a);
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (6) tick();
    rst     = 1'b1;
    start_a = 1'b1;
    tick();
    rst     = 1'b0;
    start_a = 1'b0;
    n_checks++;
    if ({busy_a, done_a, drv_a, tt_a, match_a, err_a} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b drv=%b tt=%h match=%b err=%0d, want all zero",
               busy_a, done_a, drv_a, tt_a, match_a, err_a);
    end
    n_checks++;
    if (tt_b !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_b: got tt=%h, want 00", tt_b);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    abort_a = 1'b0;
    inv_a   = 1'b0;
    start_b = 1'b0;
    abort_b = 1'b0;
    test_reset();
    test_sweep(1'b0, 8'hB2, 1'b1, 4'd0);
    test_sweep(1'b1, 8'h4D, 1'b0, (ERR_ON ? 4'd8 : 4'd0));
    test_sweep(1'b0, 8'hB2, 1'b1, 4'd0);
    test_settle0();
    test_abort();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
